// File: rtl/controlador_dma_disco_pkg.sv
// controlador_dma_disco_pkg: shared states, direction codes and default sizes for the disk DMA engine
package controlador_dma_disco_pkg;
  typedef enum logic [2:0] {IDLE, RD, WR, DONE, ERR} state_t;
  localparam logic DIR_DISK2MEM = 1'b0;
  localparam logic DIR_MEM2DISK = 1'b1;
  localparam int DEF_DISK_SIZE = 100;
  localparam int DEF_MEM_SIZE = 256;
  localparam int DEF_LEN_W = 16;
endpackage

// File: rtl/controlador_dma_disco.sv
// controlador_dma_disco: block copy engine between the word-addressed disk and main memory, 2 cycles per word
module controlador_dma_disco
  import controlador_dma_disco_pkg::*;
#(
  parameter int DISK_SIZE = DEF_DISK_SIZE,
  parameter int MEM_SIZE = DEF_MEM_SIZE,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dir,
  input  logic [31:0]      disk_base,
  input  logic [31:0]      mem_base,
  input  logic [LEN_W-1:0] length,
  output logic [31:0]      disk_addr,
  output logic             disk_we,
  output logic [31:0]      disk_wdata,
  input  logic [31:0]      disk_rdata,
  output logic [31:0]      mem_addr,
  output logic             mem_we,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic             busy,
  output logic             done,
  output logic             error
);
  state_t state, state_n;
  logic dir_q, dir_n, dwe_n, mwe_n, busy_n, done_n, err_n, oor, last;
  logic [31:0] db_q, db_n, mb_q, mb_n, buf_q, buf_n, src, da_n, ma_n, dwd_n, mwd_n;
  logic [LEN_W-1:0] len_q, len_n, idx, idx_n, idx_inc;
  logic [32:0] disk_end, mem_end;
  // range check in 33 bits so a base near 2^32 cannot wrap into the valid window
  assign disk_end = {1'b0, disk_base} + 33'(length);
  assign mem_end = {1'b0, mem_base} + 33'(length);
  assign oor = (disk_end > 33'(DISK_SIZE)) || (mem_end > 33'(MEM_SIZE));
  assign src = (dir_q == DIR_MEM2DISK) ? mem_rdata : disk_rdata;
  assign idx_inc = idx + LEN_W'(1);
  assign last = idx == len_q - LEN_W'(1);
  // outputs are registered: the comb block computes the values they take in the next state
  always_comb begin
    state_n = state;
    dir_n = dir_q;
    db_n = db_q;
    mb_n = mb_q;
    len_n = len_q;
    idx_n = idx;
    buf_n = buf_q;
    da_n = disk_addr;
    ma_n = mem_addr;
    dwd_n = disk_wdata;
    mwd_n = mem_wdata;
    dwe_n = 1'b0;
    mwe_n = 1'b0;
    busy_n = busy;
    done_n = 1'b0;
    err_n = 1'b0;
    case (state)
      IDLE: if (start) begin
        dir_n = dir;
        db_n = disk_base;
        mb_n = mem_base;
        len_n = length;
        idx_n = '0;
        state_n = (length == '0) ? DONE : oor ? ERR : RD;
        done_n = state_n == DONE;
        err_n = state_n == ERR;
        busy_n = state_n == RD;
        da_n = busy_n ? disk_base : disk_addr;
        ma_n = busy_n ? mem_base : mem_addr;
      end
      RD: begin
        state_n = WR;
        buf_n = src;
        dwe_n = dir_q == DIR_MEM2DISK;
        mwe_n = dir_q == DIR_DISK2MEM;
        dwd_n = dwe_n ? src : disk_wdata;
        mwd_n = mwe_n ? src : mem_wdata;
      end
      WR: begin
        state_n = last ? DONE : RD;
        done_n = last;
        busy_n = !last;
        idx_n = last ? idx : idx_inc;
        da_n = last ? disk_addr : db_q + 32'(idx_inc);
        ma_n = last ? mem_addr : mb_q + 32'(idx_inc);
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      dir_q <= 1'b0;
      db_q <= '0;
      mb_q <= '0;
      len_q <= '0;
      idx <= '0;
      buf_q <= '0;
      disk_addr <= '0;
      mem_addr <= '0;
      disk_wdata <= '0;
      mem_wdata <= '0;
      disk_we <= 1'b0;
      mem_we <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      state <= state_n;
      dir_q <= dir_n;
      db_q <= db_n;
      mb_q <= mb_n;
      len_q <= len_n;
      idx <= idx_n;
      buf_q <= buf_n;
      disk_addr <= da_n;
      mem_addr <= ma_n;
      disk_wdata <= dwd_n;
      mem_wdata <= mwd_n;
      disk_we <= dwe_n;
      mem_we <= mwe_n;
      busy <= busy_n;
      done <= done_n;
      error <= err_n;
    end
  end
endmodule

// File: doc/controlador_dma_disco.md
Name: controlador_dma_disco

Overview:
- Transfer engine that initiates all traffic to the word-addressed disk.
- Disk side: drives address, write enable and write data; consumes the disk's negedge-registered read data.
- Copies a block of words between disk and main memory in either direction:
  - disk-to-memory for program load at boot;
  - memory-to-disk for save.
- Sits between the CPU's I/O control path and both storage arrays; the CPU issues start and polls busy or waits for the done pulse.

Parameters:
- DISK_SIZE, 100, number of 32-bit words on the disk; valid disk addresses 0..DISK_SIZE-1.
- MEM_SIZE, 256, number of 32-bit words in main memory; valid memory addresses 0..MEM_SIZE-1.
- LEN_W, 16, width of the transfer length field.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  command strobe; sampled only in IDLE.
- dir  in  1  0 = disk-to-memory, 1 = memory-to-disk.
- disk_base  in  32  first disk word address.
- mem_base  in  32  first memory word address.
- length  in  LEN_W  word count.
- disk_addr  out  32  disk word address.
- disk_we  out  1  disk write enable.
- disk_wdata  out  32  data to disk.
- disk_rdata  in  32  data from disk; updated on negedge for the address presented that cycle.
- mem_addr  out  32  memory word address.
- mem_we  out  1  memory write enable.
- mem_wdata  out  32  data to memory.
- mem_rdata  in  32  data from memory; same timing as disk_rdata.
- busy  out  1  high from the cycle after an accepted start until the DONE cycle, exclusive.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  one-cycle pulse on a rejected command.

Behaviour:
- Reset, asynchronous on rst_n=0:
  - state=IDLE;
  - all outputs 0: addresses, data, we, busy, done, error;
  - index and buffer registers 0.
- Reset asserted mid-transfer aborts immediately. No write enable may remain asserted. No done pulse is produced.
- All outputs are registered.
- States: IDLE, RD, WR, DONE, ERR.
- IDLE, start=1: latch dir, bases and length; set idx=0.
  - length=0 -> DONE.
  - Out of range -> ERR, no array access. Out of range means disk_base+length > DISK_SIZE or mem_base+length > MEM_SIZE. Compare in 33 bits, no wrap.
  - Otherwise -> RD.
- start while not IDLE is ignored.
- RD: present source address, source = disk if dir=0, memory if dir=1.
  - Source address = base+idx; both we=0.
  - The source read data is valid by the next posedge; capture it into buf. -> WR.
- WR: present destination address = base+idx, with we=1 and wdata=buf for exactly this one cycle.
  - If idx=length-1 -> DONE; else idx+1 -> RD.
- DONE: done=1, busy=0, both we=0 -> IDLE.
- ERR: error=1, busy=0 -> IDLE.
- Throughput: 2 cycles per word.
- Latency: 2*length+1 cycles from accepting start to the done pulse, for length>0.
- The non-selected array's we stays 0 throughout a transfer.
- Overlapping source and destination ranges are not an issue: the copy goes between different arrays.
- Addresses are unsigned; idx width is LEN_W.

Decomposition:
- Shared package:
  - state encoding constants: IDLE, RD, WR, DONE, ERR;
  - DIR_DISK2MEM and DIR_MEM2DISK constants;
  - DISK_SIZE default.
- No sub-module; a single FSM with a datapath of idx, buf and address adders.

Test Plan:
- Load program, disk-to-memory:
  - Stimulus: disk preloaded with words 0..20; dir=0, disk_base=0, mem_base=0, length=21.
  - Response: memory[0..20] equals disk[0..20]; done pulses 43 cycles after start is accepted; busy high for cycles 1..42.
- Save, memory-to-disk:
  - Stimulus: mem[10..13]=A,B,C,D; dir=1, mem_base=10, disk_base=50, length=4.
  - Response: disk[50..53]=A,B,C,D; mem_we stays 0 throughout.
- Range error:
  - Stimulus: disk_base=98, length=3, DISK_SIZE=100.
  - Response: error pulses 1 cycle after start; no we asserted; busy stays 0.
- Zero length:
  - Stimulus: length=0.
  - Response: done pulses 1 cycle after start; no array access.
- Start ignored while busy:
  - Stimulus: second start during a 4-word copy.
  - Response: exactly one done pulse; first copy result intact.
- Reset mid-transfer:
  - Stimulus: rst_n=0 after word 2 of 5.
  - Response: outputs 0 immediately; disk[base+2..4] unchanged; no done pulse.
